// File: rtl/aes_round_ctrl.sv
// -----------------------------------------------------------------------------
// aes_round_ctrl
//
// Iterative AES encryption sequencer. It runs one cipher round per clock. It
// owns the 128-bit state register and the round counter, and it drives the
// expanded-key store address. It performs AddRoundKey itself. The external
// combinational round datapath supplies SubBytes/ShiftRows/MixColumns of
// dp_state; MixColumns is skipped when dp_last is high.
//
// Parameters
//   NR   number of rounds (10/12/14; 14 = AES-256)
//   RKW  round-key address width; 2**RKW must exceed NR
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   key_valid       key store holds a complete schedule (sampled in IDLE only)
//   in_valid/ready  block request handshake, in_block (byte 0 in [127:120])
//   out_valid/ready ciphertext handshake, out_block
//   rk_addr/rk_data round-key read port (combinational, same-cycle data)
//   dp_state        current state to the round datapath
//   dp_last         final round marker for the datapath
//   dp_result       SB/SR/(MC) of dp_state, without AddRoundKey
//   busy            high while a block is in flight (RUN or DONE)
//   fsm_state       current FSM state (IDLE=0, RUN=1, DONE=2) for observation
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. A producer holds valid and its payload stable until that edge.
// in_ready depends combinationally on key_valid. out_valid depends only on
// registered state.
// -----------------------------------------------------------------------------
module aes_round_ctrl #(
  parameter int NR  = 14,
  parameter int RKW = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           key_valid,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [127:0]   in_block,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [127:0]   out_block,
  output logic [RKW-1:0] rk_addr,
  input  logic [127:0]   rk_data,
  output logic [127:0]   dp_state,
  output logic           dp_last,
  input  logic [127:0]   dp_result,
  output logic           busy,
  output logic [1:0]     fsm_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_t;

  localparam logic [RKW-1:0] NR_W = RKW'(NR);

  fsm_t           fsm_q, fsm_d;
  logic [RKW-1:0] round_q, round_d;
  logic [127:0]   state_q, state_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q   <= IDLE;
      round_q <= '0;
      state_q <= '0;
    end else begin
      fsm_q   <= fsm_d;
      round_q <= round_d;
      state_q <= state_d;
    end
  end

  always_comb begin
    fsm_d     = fsm_q;
    round_d   = round_q;
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    rk_addr   = '0;
    dp_last   = 1'b0;

    case (fsm_q)
      IDLE: begin
        in_ready = key_valid;
        if (in_valid && key_valid) begin
          // rk_addr is 0 here, so rk_data is the whitening key.
          state_d = in_block ^ rk_data;
          round_d = {{(RKW-1){1'b0}}, 1'b1};
          fsm_d   = RUN;
        end
      end
      RUN: begin
        rk_addr = round_q;
        dp_last = (round_q == NR_W);
        state_d = dp_result ^ rk_data;
        // The counter stops at NR. DONE resets it, so it never wraps.
        if (round_q == NR_W) begin
          fsm_d = DONE;
        end else begin
          round_d = round_q + 1'b1;
        end
      end
      DONE: begin
        // in_ready stays low, so a new block cannot be accepted in the same
        // cycle as the result handshake. This forces one IDLE cycle between
        // blocks.
        out_valid = 1'b1;
        if (out_ready) begin
          fsm_d   = IDLE;
          round_d = '0;
        end
      end
      default: begin
        fsm_d   = IDLE;
        round_d = '0;
      end
    endcase

    // While reset is asserted, the outputs already show their reset values,
    // so no accept or delivery can be seen on the reset edge.
    if (rst) begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      rk_addr   = '0;
      dp_last   = 1'b0;
    end
  end

  assign dp_state  = state_q;
  assign out_block = state_q;
  assign busy      = (fsm_q != IDLE) && !rst;
  assign fsm_state = fsm_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// -----------------------------------------------------------------------------
// tb_aes_round_ctrl
//
// Bench for aes_round_ctrl (AES-256, NR=14). The bench provides the expanded
// key store and the combinational round datapath around the controller. It
// checks ciphertext, timing and handshake behaviour against a whole-block AES
// reference model.
// -----------------------------------------------------------------------------
module tb_aes_round_ctrl;

  localparam int NR  = 14;
  localparam int RKW = 4;

  localparam logic [255:0] C3_KEY  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] C3_PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C3_CT   = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] C3_RUN1 = 128'h00102030405060708090a0b0c0d0e0f0;

  // ---------------- clock / reset / DUT ----------------
  logic           clk = 1'b0;
  logic           rst;
  logic           key_valid;
  logic           in_valid;
  logic           in_ready;
  logic [127:0]   in_block;
  logic           out_valid;
  logic           out_ready;
  logic [127:0]   out_block;
  logic [RKW-1:0] rk_addr;
  logic [127:0]   rk_data;
  logic [127:0]   dp_state;
  logic           dp_last;
  logic [127:0]   dp_result;
  logic           busy;
  logic [1:0]     fsm_state;

  always #5 clk = ~clk;

  aes_round_ctrl #(.NR(NR), .RKW(RKW)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_valid (key_valid),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_block  (in_block),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_block (out_block),
    .rk_addr   (rk_addr),
    .rk_data   (rk_data),
    .dp_state  (dp_state),
    .dp_last   (dp_last),
    .dp_result (dp_result),
    .busy      (busy),
    .fsm_state (fsm_state)
  );

  int vectors     = 0;
  int miscompares = 0;
  logic [127:0] exp_q[$];

  logic [7:0]   sbox   [256];
  logic [127:0] rk_mem [16];

  // ---------------- AES reference pieces ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xt(x);
      y = y >> 1;
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] round_fn(input logic [127:0] s, input logic last);
    logic [7:0] a [16];
    logic [7:0] b [16];
    logic [7:0] m0, m1, m2, m3;
    logic [127:0] r;
    for (int i = 0; i < 16; i++) a[i] = sbox[s[127-8*i -: 8]];
    for (int c = 0; c < 4; c++)
      for (int rr = 0; rr < 4; rr++)
        b[rr+4*c] = a[rr + 4*((c+rr)%4)];
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        m0 = b[4*c]; m1 = b[4*c+1]; m2 = b[4*c+2]; m3 = b[4*c+3];
        b[4*c]   = xt(m0) ^ xt(m1) ^ m1 ^ m2 ^ m3;
        b[4*c+1] = m0 ^ xt(m1) ^ xt(m2) ^ m2 ^ m3;
        b[4*c+2] = m0 ^ m1 ^ xt(m2) ^ xt(m3) ^ m3;
        b[4*c+3] = xt(m0) ^ m0 ^ m1 ^ m2 ^ xt(m3);
      end
    end
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = b[i];
    return r;
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  task automatic expand_key(input logic [255:0] key);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) begin
        t = subword({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
        rcon = xt(rcon);
      end else if (i % 8 == 4) begin
        t = subword(t);
      end
      w[i] = w[i-8] ^ t;
    end
    for (int r = 0; r <= NR; r++) rk_mem[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    rk_mem[15] = '0;
  endtask

  // Whole-block cipher: whitening, then NR rounds with the last one lacking MixColumns.
  function automatic logic [127:0] aes_model(input logic [127:0] pt);
    logic [127:0] s;
    s = pt ^ rk_mem[0];
    for (int r = 1; r <= NR; r++) s = round_fn(s, r == NR) ^ rk_mem[r];
    return s;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Environment: key store and combinational round datapath.
  assign rk_data = rk_mem[rk_addr];
  always_comb dp_result = round_fn(dp_state, dp_last);

  // ---------------- driver tasks ----------------
  task automatic accept_block(input logic [127:0] pt);
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk); in_valid = 1'b1; in_block = pt; #1;
      if (in_ready) ok = 1'b1;
    end
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL accept_timeout: in_ready got 0 expected 1 within 50 cycles");
    end
  endtask

  task automatic wait_out(output int n);
    n = 0;
    for (int t = 1; t <= 40 && n == 0; t++) begin
      @(negedge clk); in_valid = 1'b0; #1;
      if (out_valid) n = t;
    end
    vectors++;
    if (n == 0) begin
      miscompares++;
      $display("FAIL out_timeout: out_valid got 0 expected 1 within 40 cycles");
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; key_valid = 1'b1; in_valid = 1'b1; in_block = C3_PT; out_ready = 1'b1;
    @(negedge clk); @(negedge clk); #1;
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready: got %0b expected 0", in_ready); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    vectors++; if (dp_last !== 1'b0) begin miscompares++; $display("FAIL reset_dp_last: got %0b expected 0", dp_last); end
    vectors++; if (rk_addr !== 4'd0) begin miscompares++; $display("FAIL reset_rk_addr: got %0d expected 0", rk_addr); end
    vectors++; if (dp_state !== 128'h0) begin miscompares++; $display("FAIL reset_state: got %h expected 0", dp_state); end
    vectors++; if (fsm_state !== 2'd0) begin miscompares++; $display("FAIL reset_fsm: got %0d expected 0 (IDLE)", fsm_state); end
    @(negedge clk); rst = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_c3();
    int first_ov, last_cnt;
    logic [RKW-1:0] addr_nr;
    logic last_nr;
    first_ov = 0; last_cnt = 0; addr_nr = '0; last_nr = 1'b0;
    vectors++;
    if (aes_model(C3_PT) !== C3_CT) begin
      miscompares++; $display("FAIL model_c3: got %h expected %h", aes_model(C3_PT), C3_CT);
    end
    accept_block(C3_PT);
    for (int n = 1; n <= NR + 5 && first_ov == 0; n++) begin
      @(negedge clk); in_valid = 1'b0; out_ready = 1'b0; #1;
      if (n == 1) begin
        vectors++; if (dp_state !== C3_RUN1) begin miscompares++; $display("FAIL c3_run1_state: got %h expected %h", dp_state, C3_RUN1); end
        vectors++; if (rk_addr !== 4'd1) begin miscompares++; $display("FAIL c3_run1_rk_addr: got %0d expected 1", rk_addr); end
        vectors++; if (dp_last !== 1'b0) begin miscompares++; $display("FAIL c3_run1_dp_last: got %0b expected 0", dp_last); end
      end
      if (n == NR) begin addr_nr = rk_addr; last_nr = dp_last; end
      if (dp_last) last_cnt++;
      if (out_valid) first_ov = n;
    end
    vectors++; if (addr_nr !== RKW'(NR)) begin miscompares++; $display("FAIL c3_last_rk_addr: got %0d expected %0d", addr_nr, NR); end
    vectors++; if (last_nr !== 1'b1) begin miscompares++; $display("FAIL c3_last_dp_last: got %0b expected 1", last_nr); end
    vectors++; if (last_cnt != 1) begin miscompares++; $display("FAIL c3_dp_last_count: got %0d expected 1", last_cnt); end
    vectors++; if (first_ov != NR + 1) begin miscompares++; $display("FAIL c3_latency: got %0d expected %0d", first_ov, NR + 1); end
    vectors++; if (out_block !== C3_CT) begin miscompares++; $display("FAIL c3_ciphertext: got %h expected %h", out_block, C3_CT); end
    out_ready = 1'b1;
    @(negedge clk); #1;
    vectors++; if (busy !== 1'b0 || out_valid !== 1'b0) begin
      miscompares++; $display("FAIL c3_release: busy/out_valid got %0b/%0b expected 0/0", busy, out_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] pt1, pt2, exp1;
    int n;
    pt1 = rand128(); pt2 = rand128(); exp1 = aes_model(pt1);
    out_ready = 1'b0;
    accept_block(pt1);
    wait_out(n);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      in_valid = 1'b1; in_block = pt2; #1;
      vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_hold_valid[%0d]: got %0b expected 1", k, out_valid); end
      vectors++; if (out_block !== exp1) begin miscompares++; $display("FAIL bp_hold_block[%0d]: got %h expected %h", k, out_block, exp1); end
      vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_hold_in_ready[%0d]: got %0b expected 0", k, in_ready); end
    end
    @(negedge clk); out_ready = 1'b1; #1;
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_same_cycle_accept: in_ready got %0b expected 0", in_ready); end
    @(negedge clk); out_ready = 1'b0; #1;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL bp_idle_busy: got %0b expected 0", busy); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_idle_in_ready: got %0b expected 1", in_ready); end
    @(negedge clk); in_valid = 1'b0; #1;
    vectors++; if (dp_state !== (pt2 ^ rk_mem[0])) begin miscompares++; $display("FAIL bp_second_whiten: got %h expected %h", dp_state, pt2 ^ rk_mem[0]); end
    wait_out(n);
    vectors++; if (n != NR) begin miscompares++; $display("FAIL bp_second_latency: got %0d expected %0d", n, NR); end
    vectors++; if (out_block !== aes_model(pt2)) begin miscompares++; $display("FAIL bp_second_block: got %h expected %h", out_block, aes_model(pt2)); end
    out_ready = 1'b1;
  endtask

  task automatic test_keyvalid();
    logic [127:0] pt, snap;
    int n;
    pt = rand128();
    key_valid = 1'b0;
    @(negedge clk); #1; snap = dp_state;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); in_valid = 1'b1; in_block = pt; #1;
      vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL kv_in_ready[%0d]: got %0b expected 0", k, in_ready); end
      vectors++; if (busy !== 1'b0 || dp_state !== snap) begin
        miscompares++; $display("FAIL kv_no_change[%0d]: busy %0b state %h expected 0 %h", k, busy, dp_state, snap);
      end
    end
    @(negedge clk); key_valid = 1'b1; #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL kv_raise_accept: in_ready got %0b expected 1", in_ready); end
    @(negedge clk); in_valid = 1'b0; key_valid = 1'b0; #1;
    vectors++; if (busy !== 1'b1 || dp_state !== (pt ^ rk_mem[0])) begin
      miscompares++; $display("FAIL kv_started: busy %0b state %h expected 1 %h", busy, dp_state, pt ^ rk_mem[0]);
    end
    // key_valid stays low for the rest of the block; the block must still finish.
    wait_out(n);
    vectors++; if (out_block !== aes_model(pt)) begin miscompares++; $display("FAIL kv_block: got %h expected %h", out_block, aes_model(pt)); end
    key_valid = 1'b1;
  endtask

  task automatic test_mid_reset();
    int n;
    out_ready = 1'b1;
    accept_block(C3_PT);
    for (int k = 1; k <= 7; k++) begin @(negedge clk); in_valid = 1'b0; #1; end
    vectors++; if (rk_addr !== 4'd7) begin miscompares++; $display("FAIL mr_round7: rk_addr got %0d expected 7", rk_addr); end
    rst = 1'b1;
    @(negedge clk); rst = 1'b0; #1;
    vectors++; if (fsm_state !== 2'd0) begin miscompares++; $display("FAIL mr_fsm: got %0d expected 0 (IDLE)", fsm_state); end
    vectors++; if (out_valid !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL mr_flags: out_valid/busy got %0b/%0b expected 0/0", out_valid, busy); end
    vectors++; if (dp_state !== 128'h0) begin miscompares++; $display("FAIL mr_state: got %h expected 0", dp_state); end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); #1;
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL mr_no_pulse[%0d]: out_valid got %0b expected 0", k, out_valid); end
    end
    accept_block(C3_PT);
    wait_out(n);
    vectors++; if (n != NR + 1) begin miscompares++; $display("FAIL mr_fresh_latency: got %0d expected %0d", n, NR + 1); end
    vectors++; if (out_block !== C3_CT) begin miscompares++; $display("FAIL mr_fresh_block: got %h expected %h", out_block, C3_CT); end
  endtask

  task automatic test_back_to_back();
    logic [127:0] pts [4];
    logic [127:0] exp;
    int acc_cyc [4];
    int idx, got;
    // Load a random key while the controller is idle and key_valid is low.
    @(negedge clk); key_valid = 1'b0; in_valid = 1'b0;
    expand_key({rand128(), rand128()});
    for (int i = 0; i < 4; i++) begin pts[i] = rand128(); acc_cyc[i] = 0; end
    exp_q.delete();
    idx = 0; got = 0;
    out_ready = 1'b1; key_valid = 1'b1;
    for (int c = 0; c < 200 && got < 4; c++) begin
      @(negedge clk);
      if (idx < 4) begin in_valid = 1'b1; in_block = pts[idx]; end
      else in_valid = 1'b0;
      #1;
      if (out_valid && out_ready) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++; $display("FAIL b2b_unexpected_out: got %h expected no output", out_block);
        end else begin
          exp = exp_q.pop_front();
          if (out_block !== exp) begin miscompares++; $display("FAIL b2b_block[%0d]: got %h expected %h", got, out_block, exp); end
        end
        got++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(aes_model(pts[idx]));
        acc_cyc[idx] = c;
        idx++;
      end
    end
    in_valid = 1'b0;
    vectors++; if (got != 4) begin miscompares++; $display("FAIL b2b_count: got %0d expected 4", got); end
    for (int i = 1; i < 4; i++) begin
      vectors++;
      if (acc_cyc[i] - acc_cyc[i-1] != NR + 2) begin
        miscompares++; $display("FAIL b2b_interval[%0d]: got %0d expected %0d", i, acc_cyc[i] - acc_cyc[i-1], NR + 2);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1; key_valid = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_block = '0;
    build_sbox();
    expand_key(C3_KEY);
    test_reset();
    test_c3();
    test_backpressure();
    test_keyvalid();
    test_mid_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
